draw_write_arbiter: RTL
=======================

# draw_write_arbiter

Per-frame scheduler for the shared draw-manager write bus. On each `frame` pulse it optionally clears the framebuffer, then grants the tri-stated write bus to each enabled draw source (starfield, sprites, HUD, …) in fixed ascending order. It forwards every accepted pixel to the framebuffer write port and finally requests a buffer swap from the display side.

## Interface
Parameters:
- `SOURCE_COUNT`, 4: number of draw sources; IDs 0..SOURCE_COUNT-1.
- `SEL_WIDTH`, $clog2(SOURCE_COUNT+1): width of `write_source_sel`; all-ones is the idle code and must not be a valid source ID.
- `COLOR_DEPTH`, 9: pixel color width.
- `DRAW_WIDTH`, 640; `DRAW_HEIGHT`, 480: framebuffer geometry.
- `CLEAR_EN`, 1: clear pass enabled at the start of each frame.
- `BG_COLOR`, 9'b000000000: clear color.
- `GRANT_TIMEOUT`, 1024: cycles a granted source may take to raise `write_active` before it is skipped.

Ports:
- `clk` in 1: clock.
- `resetN` in 1: reset, synchronous, active-low.
- `frame` in 1: one-cycle start-of-frame pulse.
- `src_en` in SOURCE_COUNT: per-source enable; sampled when the scan selects the next source.
- `write_source_sel` out SEL_WIDTH: ID of the source owning the bus; all-ones when idle.
- `write_awaited` out 1: granted source may begin its burst.
- `write_active` in 1: shared bus, burst valid.
- `write_color_data` in COLOR_DEPTH: shared bus, pixel color.
- `write_transparent` in 1: shared bus, pixel is suppressed.
- `write_x_addr`, `write_y_addr` in 32: shared bus, pixel coordinates, treated as unsigned.
- `fb_we` out 1; `fb_addr` out 19; `fb_data` out COLOR_DEPTH: framebuffer write port.
- `swap_req` out 1; `swap_ack` in 1: buffer-swap handshake.
- `busy` out 1: high in every state except IDLE.
- `frame_missed` out 1: one-cycle pulse when `frame` arrives while busy.
- `grant_timeout` out 1: one-cycle pulse when a source is skipped.

## Operation
States: IDLE, CLEAR, SCAN, GRANT, DRAIN, SWAP.
- IDLE: `frame`=1 goes to CLEAR if CLEAR_EN, else to SCAN, with scan index starting at 0.
- CLEAR: 19-bit counter runs 0..DRAW_WIDTH*DRAW_HEIGHT-1.
  - Each cycle drives `fb_we`=1, `fb_addr`=counter, `fb_data`=BG_COLOR.
  - After the last address, goes to SCAN with index 0.
- SCAN: one cycle, bus turnaround; `write_source_sel`=idle code.
  - Picks the lowest enabled source with ID ≥ the scan index and goes to GRANT.
  - If no enabled source remains, goes to SWAP.
- GRANT k: `write_source_sel`=k, `write_awaited`=1, timeout counter increments.
  - `write_active`=1 goes to DRAIN; the pixel on the bus that cycle is accepted.
  - Counter reaching GRANT_TIMEOUT-1 pulses `grant_timeout`, sets scan index k+1 and goes to SCAN.
- DRAIN k: `write_awaited`=0 and `write_source_sel` stays k.
  - Each cycle with `write_active`=1 presents a pixel.
  - `write_active`=0 ends the burst: scan index k+1, go to SCAN.
  - No burst length limit.
- Pixel acceptance: requires `write_active` && !`write_transparent` && x < DRAW_WIDTH && y < DRAW_HEIGHT. Negative coordinates are large when unsigned and are therefore rejected.
- Framebuffer address: fb_addr = y*DRAW_WIDTH + x. For 640 this is computed as (y<<9)+(y<<7)+x, truncated to 19 bits.
- SWAP: `swap_req`=1 until `swap_ack` is sampled high, then IDLE. `swap_req` drops in the cycle after the ack.
- `frame` while busy: ignored, pulses `frame_missed`; it is not queued.
- `src_en` changing mid-frame: affects only sources not yet scanned.

## Timing
- Reset (`resetN`=0 at an edge) applies at the next edge and aborts any pass, including mid-burst and mid-CLEAR.
  - State goes to IDLE and `write_source_sel` to the idle code.
  - `write_awaited`, `fb_we`, `swap_req`, `busy`, `frame_missed`, `grant_timeout` go to 0; the pixel pipeline register is cleared.
- `frame` at edge N gives `busy`=1 and the first CLEAR write (or SCAN) from N+1.
- CLEAR takes exactly DRAW_WIDTH*DRAW_HEIGHT cycles.
- Pixel latency: 1 cycle. A bus pixel sampled at edge N appears on `fb_we`/`fb_addr`/`fb_data` after edge N+1; all three are registered.
- `fb_we` is never asserted for rejected pixels.
- Grant to burst: `write_awaited` is high from the first GRANT cycle and low from the cycle after `write_active` is first sampled high. This prevents a source from re-arming off a stale await.
- Per-source overhead is 1 SCAN cycle, plus 1 GRANT cycle when the source answers immediately.
- `swap_req` rises at least 2 cycles after the last accepted pixel is sampled, so the final `fb_we` completes before it.
- `frame` coincident with the `swap_ack` cycle still counts as busy and pulses `frame_missed`.

## Test plan
- **Clear and empty pass.** CLEAR_EN=1, `src_en`=0, pulse `frame`.
  - Expect 307200 consecutive `fb_we` with BG_COLOR, last `fb_addr`=307199.
  - Then `swap_req`; `swap_ack` after 3 cycles returns to IDLE with `busy`=0.
- **Single source, 50-pixel burst.** CLEAR_EN=0, source 0 answers `write_awaited` after 1 cycle with 50 pixels.
  - Pixel (639,479) writes `fb_addr`=307199; pixel (0,1) writes `fb_addr`=640.
  - Each write lands 1 cycle after its bus sample; `write_awaited` is low during the burst.
- **Rejection.** Burst containing x=640, y=480, x=32'hFFFF_FFF6 (−10) and a transparent pixel.
  - Expect zero `fb_we` for those pixels; neighbouring valid pixels are still written.
- **Timeout.** `src_en`=4'b0101, source 0 never responds.
  - `grant_timeout` pulses after 1024 GRANT cycles; source 2 is then granted.
  - Source 1 is never selected.
- **Overrun and reset.** Pulse `frame` during source 2's burst: expect `frame_missed` with no effect on the pass.
  - Then assert `resetN`=0 mid-burst: next cycle `write_source_sel`=idle code and `fb_we`=0; no further writes.

Source files
------------

// File: rtl/draw_write_arbiter.sv
// draw_write_arbiter
// Per-frame scheduler for the shared draw-manager write bus. On each frame
// pulse it optionally clears the framebuffer, then grants the shared write bus
// to every enabled draw source in ascending ID order. Each accepted pixel is
// forwarded to the framebuffer write port, and the pass ends with a buffer-swap
// handshake towards the display side.
module draw_write_arbiter #(
  parameter int                     SOURCE_COUNT  = 4,
  parameter int                     SEL_WIDTH     = $clog2(SOURCE_COUNT + 1),
  parameter int                     COLOR_DEPTH   = 9,
  parameter int                     DRAW_WIDTH    = 640,
  parameter int                     DRAW_HEIGHT   = 480,
  parameter bit                     CLEAR_EN      = 1'b1,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR      = '0,
  parameter int                     GRANT_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    frame,
  input  logic [SOURCE_COUNT-1:0] src_en,
  output logic [SEL_WIDTH-1:0]    write_source_sel,
  output logic                    write_awaited,
  input  logic                    write_active,
  input  logic [COLOR_DEPTH-1:0]  write_color_data,
  input  logic                    write_transparent,
  input  logic [31:0]             write_x_addr,
  input  logic [31:0]             write_y_addr,
  output logic                    fb_we,
  output logic [18:0]             fb_addr,
  output logic [COLOR_DEPTH-1:0]  fb_data,
  output logic                    swap_req,
  input  logic                    swap_ack,
  output logic                    busy,
  output logic                    frame_missed,
  output logic                    grant_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_GRANT = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_SWAP  = 3'd5;

  // All-ones never names a real source, so it doubles as "bus parked".
  localparam logic [SEL_WIDTH-1:0] IDLE_SEL = '1;

  localparam int          FB_SIZE    = DRAW_WIDTH * DRAW_HEIGHT;
  localparam logic [18:0] CLEAR_LAST = 19'(FB_SIZE - 1);

  localparam int                  TO_WIDTH = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(GRANT_TIMEOUT - 1);

  logic [2:0]             state_q,         state_d;
  logic [SEL_WIDTH-1:0]   scanIdx_q,       scanIdx_d;
  logic [SEL_WIDTH-1:0]   curSrc_q,        curSrc_d;
  logic [18:0]            clearCnt_q,      clearCnt_d;
  logic [TO_WIDTH-1:0]    toCnt_q,         toCnt_d;
  logic                   fbWe_q,          fbWe_d;
  logic [18:0]            fbAddr_q,        fbAddr_d;
  logic [COLOR_DEPTH-1:0] fbData_q,        fbData_d;
  logic                   frameMissed_q,   frameMissed_d;
  logic                   grantTimeout_q,  grantTimeout_d;

  logic                   pixInRange;
  logic                   pixAccept;
  logic [18:0]            pixAddr;
  logic [18:0]            xLow;
  logic [18:0]            yLow;
  logic                   scanFound;
  logic [SEL_WIDTH-1:0]   scanPick;

  assign xLow = write_x_addr[18:0];
  assign yLow = write_y_addr[18:0];

  // Coordinates are unsigned, so negative values from a source land far out of
  // range and are dropped by the same compare that handles the right/bottom edge.
  always_comb begin
    pixInRange = (write_x_addr < 32'(DRAW_WIDTH)) && (write_y_addr < 32'(DRAW_HEIGHT));
    pixAccept  = write_active && !write_transparent && pixInRange;
  end

  // Row-major framebuffer address; the 640-wide case folds into two shifts.
  generate
    if (DRAW_WIDTH == 640) begin : g_addr640
      assign pixAddr = (yLow << 9) + (yLow << 7) + xLow;
    end else begin : g_addrGeneric
      assign pixAddr = (yLow * 19'(DRAW_WIDTH)) + xLow;
    end
  endgenerate

  // Find the lowest enabled source at or above the scan index; iterating
  // downwards lets the lowest match overwrite any higher one.
  always_comb begin
    scanFound = 1'b0;
    scanPick  = IDLE_SEL;
    for (int i = SOURCE_COUNT - 1; i >= 0; i--) begin
      if (src_en[i] && (SEL_WIDTH'(i) >= scanIdx_q)) begin
        scanFound = 1'b1;
        scanPick  = SEL_WIDTH'(i);
      end
    end
  end

  // Pass sequencing plus the registered framebuffer write and status pulses.
  always_comb begin
    state_d        = state_q;
    scanIdx_d      = scanIdx_q;
    curSrc_d       = curSrc_q;
    clearCnt_d     = clearCnt_q;
    toCnt_d        = toCnt_q;
    fbWe_d         = 1'b0;
    fbAddr_d       = fbAddr_q;
    fbData_d       = fbData_q;
    frameMissed_d  = frame && (state_q != S_IDLE);
    grantTimeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame) begin
          scanIdx_d = '0;
          if (CLEAR_EN) begin
            // Preload the first clear write so it is visible in the first CLEAR cycle.
            state_d    = S_CLEAR;
            clearCnt_d = '0;
            fbWe_d     = 1'b1;
            fbAddr_d   = '0;
            fbData_d   = BG_COLOR;
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_CLEAR: begin
        if (clearCnt_q == CLEAR_LAST) begin
          state_d = S_SCAN;
        end else begin
          clearCnt_d = clearCnt_q + 19'd1;
          fbWe_d     = 1'b1;
          fbAddr_d   = clearCnt_q + 19'd1;
          fbData_d   = BG_COLOR;
        end
      end

      S_SCAN: begin
        if (scanFound) begin
          state_d  = S_GRANT;
          curSrc_d = scanPick;
          toCnt_d  = '0;
        end else begin
          state_d = S_SWAP;
        end
      end

      S_GRANT: begin
        if (write_active) begin
          state_d  = S_DRAIN;
          fbWe_d   = pixAccept;
          if (pixAccept) begin
            fbAddr_d = pixAddr;
            fbData_d = write_color_data;
          end
        end else if (toCnt_q == TO_LAST) begin
          grantTimeout_d = 1'b1;
          scanIdx_d      = curSrc_q + SEL_WIDTH'(1);
          state_d        = S_SCAN;
        end else begin
          toCnt_d = toCnt_q + TO_WIDTH'(1);
        end
      end

      S_DRAIN: begin
        if (write_active) begin
          fbWe_d = pixAccept;
          if (pixAccept) begin
            fbAddr_d = pixAddr;
            fbData_d = write_color_data;
          end
        end else begin
          scanIdx_d = curSrc_q + SEL_WIDTH'(1);
          state_d   = S_SCAN;
        end
      end

      S_SWAP: begin
        if (swap_ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Synchronous active-low reset aborts any pass, including mid-clear and mid-burst.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q        <= S_IDLE;
      scanIdx_q      <= '0;
      curSrc_q       <= '0;
      clearCnt_q     <= '0;
      toCnt_q        <= '0;
      fbWe_q         <= 1'b0;
      fbAddr_q       <= '0;
      fbData_q       <= '0;
      frameMissed_q  <= 1'b0;
      grantTimeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      scanIdx_q      <= scanIdx_d;
      curSrc_q       <= curSrc_d;
      clearCnt_q     <= clearCnt_d;
      toCnt_q        <= toCnt_d;
      fbWe_q         <= fbWe_d;
      fbAddr_q       <= fbAddr_d;
      fbData_q       <= fbData_d;
      frameMissed_q  <= frameMissed_d;
      grantTimeout_q <= grantTimeout_d;
    end
  end

  // Bus ownership is shown only while a source holds the grant or is draining.
  always_comb begin
    write_source_sel = ((state_q == S_GRANT) || (state_q == S_DRAIN)) ? curSrc_q : IDLE_SEL;
    write_awaited    = (state_q == S_GRANT);
    swap_req         = (state_q == S_SWAP);
    busy             = (state_q != S_IDLE);
    fb_we            = fbWe_q;
    fb_addr          = fbAddr_q;
    fb_data          = fbData_q;
    frame_missed     = frameMissed_q;
    grant_timeout    = grantTimeout_q;
  end

endmodule
